// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT wrapper bus master: register map,
// FSM state encoding and the per-state bus drive pattern.
package present_pkg;

    // Register map of the PRESENT wrapper
    localparam logic [3:0] ADDR_LOAD    = 4'h0;
    localparam logic [3:0] ADDR_KEY_LO  = 4'h1;
    localparam logic [3:0] ADDR_KEY_MID = 4'h2;
    localparam logic [3:0] ADDR_KEY_HI  = 4'h3;
    localparam logic [3:0] ADDR_DAT_LO  = 4'h4;
    localparam logic [3:0] ADDR_DAT_HI  = 4'h5;
    localparam logic [3:0] ADDR_RES_LO  = 4'h6;
    localparam logic [3:0] ADDR_RES_HI  = 4'h7;
    localparam logic [3:0] ADDR_CTRL    = 4'h8;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WR_K3  = 4'd1,
        S_WR_K2  = 4'd2,
        S_WR_K1  = 4'd3,
        S_WR_CTL = 4'd4,
        S_WR_DHI = 4'd5,
        S_WR_DLO = 4'd6,
        S_WR_LD  = 4'd7,
        S_CLR_LD = 4'd8,
        S_WAIT   = 4'd9,
        S_RD_HI  = 4'd10,
        S_RD_LO  = 4'd11,
        S_CAP    = 4'd12,
        S_OUT    = 4'd13
    } state_t;

    typedef struct packed {
        logic        cs_n;
        logic        write_n;
        logic        read_n;
        logic [3:0]  addr;
        logic [31:0] dat;
    } bus_t;

    // Bus pattern presented while the FSM sits in state s
    function automatic bus_t bus_for(input state_t s, input logic [79:0] key,
                                     input logic mode, input logic [63:0] blk);
        bus_t r;
        r.cs_n    = 1'b1;
        r.write_n = 1'b1;
        r.read_n  = 1'b1;
        r.addr    = ADDR_LOAD;
        r.dat     = 32'h0;
        case (s)
            S_WR_K3: begin
                r.cs_n = 1'b0; r.write_n = 1'b0; r.addr = ADDR_KEY_HI;  r.dat = key[79:48];
            end
            S_WR_K2: begin
                r.cs_n = 1'b0; r.write_n = 1'b0; r.addr = ADDR_KEY_MID; r.dat = key[47:16];
            end
            S_WR_K1: begin
                r.cs_n = 1'b0; r.write_n = 1'b0; r.addr = ADDR_KEY_LO;  r.dat = {16'h0, key[15:0]};
            end
            S_WR_CTL: begin
                r.cs_n = 1'b0; r.write_n = 1'b0; r.addr = ADDR_CTRL;    r.dat = {31'h0, mode};
            end
            S_WR_DHI: begin
                r.cs_n = 1'b0; r.write_n = 1'b0; r.addr = ADDR_DAT_HI;  r.dat = blk[63:32];
            end
            S_WR_DLO: begin
                r.cs_n = 1'b0; r.write_n = 1'b0; r.addr = ADDR_DAT_LO;  r.dat = blk[31:0];
            end
            S_WR_LD: begin
                r.cs_n = 1'b0; r.write_n = 1'b0; r.addr = ADDR_LOAD;    r.dat = 32'h1;
            end
            // Selected with neither strobe: the wrapper drops its load bit
            S_CLR_LD: begin
                r.cs_n = 1'b0;
            end
            S_RD_HI: begin
                r.cs_n = 1'b0; r.read_n = 1'b0; r.addr = ADDR_RES_HI;
            end
            S_RD_LO: begin
                r.cs_n = 1'b0; r.read_n = 1'b0; r.addr = ADDR_RES_LO;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/present_block_feeder.sv
// Bus master in front of the PRESENT register wrapper. Takes one block
// (with key and mode) at a time, programs the wrapper, waits out the core
// latency, reads the result back and offers it over valid/ready.
// The key and control registers are only rewritten when they differ from
// what was last programmed.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | ready for a new block
// WR_K3    | write key[79:48] to addr 3
// WR_K2    | write key[47:16] to addr 2
// WR_K1    | write key[15:0]  to addr 1
// WR_CTL   | write mode to addr 8, remember key/mode
// WR_DHI   | write block[63:32] to addr 5
// WR_DLO   | write block[31:0]  to addr 4
// WR_LD    | write 1 to addr 0, core load rises
// CLR_LD   | select without strobe, core load falls, arm wait
// WAIT     | count down the core latency
// RD_HI    | read addr 7
// RD_LO    | read addr 6, capture upper result word
// CAP      | capture lower result word, raise oValid
// OUT      | hold result until iReady
module present_block_feeder
    import present_pkg::*;
#(
    parameter int CORE_LATENCY = 34,
    parameter int WAIT_W       = 6
) (
    input  logic        clk,
    input  logic        iReset,
    input  logic        iValid,
    output logic        oReady,
    input  logic [63:0] iBlock,
    input  logic [79:0] iKey,
    input  logic        iMode,
    output logic        oValid,
    input  logic        iReady,
    output logic [63:0] oBlock,
    output logic        oChipselect_n,
    output logic        oWrite_n,
    output logic        oRead_n,
    output logic [3:0]  oAddress,
    output logic [31:0] oDat,
    input  logic [31:0] iDat
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CORE_LATENCY - 1);

    state_t            state;
    state_t            state_next;
    bus_t              bus_next;
    logic [63:0]       blk;
    logic [79:0]       key;
    logic              mode;
    logic [79:0]       shadow_key;
    logic              shadow_mode;
    logic              key_loaded;
    logic [WAIT_W-1:0] wait_cnt;
    logic              accept;
    logic              need_key;
    logic [79:0]       key_src;
    logic [63:0]       blk_src;
    logic              mode_src;

    assign oReady   = (state == S_IDLE);
    assign accept   = iValid & oReady;
    assign need_key = !key_loaded || (iKey != shadow_key) || (iMode != shadow_mode);

    // The first write after accept is set up in IDLE, before the inputs are latched
    assign key_src  = oReady ? iKey   : key;
    assign blk_src  = oReady ? iBlock : blk;
    assign mode_src = oReady ? iMode  : mode;

    // Next-state decode and the registered bus pattern for that state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = need_key ? S_WR_K3 : S_WR_DHI;
            S_WR_K3:  state_next = S_WR_K2;
            S_WR_K2:  state_next = S_WR_K1;
            S_WR_K1:  state_next = S_WR_CTL;
            S_WR_CTL: state_next = S_WR_DHI;
            S_WR_DHI: state_next = S_WR_DLO;
            S_WR_DLO: state_next = S_WR_LD;
            S_WR_LD:  state_next = S_CLR_LD;
            S_CLR_LD: state_next = S_WAIT;
            S_WAIT:   if (wait_cnt == '0) state_next = S_RD_HI;
            S_RD_HI:  state_next = S_RD_LO;
            S_RD_LO:  state_next = S_CAP;
            S_CAP:    state_next = S_OUT;
            S_OUT:    if (iReady) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        bus_next = bus_for(state_next, key_src, mode_src, blk_src);
    end

    // State register and registered bus outputs
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            state         <= S_IDLE;
            oChipselect_n <= 1'b1;
            oWrite_n      <= 1'b1;
            oRead_n       <= 1'b1;
            oAddress      <= 4'h0;
            oDat          <= 32'h0;
        end else begin
            state         <= state_next;
            oChipselect_n <= bus_next.cs_n;
            oWrite_n      <= bus_next.write_n;
            oRead_n       <= bus_next.read_n;
            oAddress      <= bus_next.addr;
            oDat          <= bus_next.dat;
        end
    end

    // Input latch, key shadow, wait counter and result capture
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            blk         <= 64'h0;
            key         <= 80'h0;
            mode        <= 1'b0;
            shadow_key  <= 80'h0;
            shadow_mode <= 1'b0;
            key_loaded  <= 1'b0;
            wait_cnt    <= '0;
            oBlock      <= 64'h0;
            oValid      <= 1'b0;
        end else begin
            if (accept) begin
                blk  <= iBlock;
                key  <= iKey;
                mode <= iMode;
            end
            if (state == S_WR_CTL) begin
                shadow_key  <= key;
                shadow_mode <= mode;
                key_loaded  <= 1'b1;
            end
            if (state == S_CLR_LD) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
            if (state == S_RD_LO) oBlock[63:32] <= iDat;
            if (state == S_CAP)   oBlock[31:0]  <= iDat;
            if (state == S_CAP) begin
                oValid <= 1'b1;
            end else if (state == S_OUT && iReady) begin
                oValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_present_block_feeder.sv
// Directed bench for present_block_feeder. A behavioural PRESENT wrapper
// (register map plus a PRESENT-80 encryption model) acts as the load.
module tb_present_block_feeder;
    import present_pkg::*;

    logic        clk;
    logic        iReset;
    logic        iValid;
    logic        oReady;
    logic [63:0] iBlock;
    logic [79:0] iKey;
    logic        iMode;
    logic        oValid;
    logic        iReady;
    logic [63:0] oBlock;
    logic        oChipselect_n;
    logic        oWrite_n;
    logic        oRead_n;
    logic [3:0]  oAddress;
    logic [31:0] oDat;
    logic [31:0] iDat;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Accept edge to oValid edge: 8 setup cycles with key (K3..CLR_LD),
    // 34 wait cycles, 3 read-back cycles; 4 fewer without key/ctrl writes.
    localparam int LAT_KEY   = 45;
    localparam int LAT_NOKEY = 41;
    localparam int MODEL_LAT = 34;

    present_block_feeder #(.CORE_LATENCY(34), .WAIT_W(6)) dut (
        .clk(clk), .iReset(iReset), .iValid(iValid), .oReady(oReady),
        .iBlock(iBlock), .iKey(iKey), .iMode(iMode), .oValid(oValid),
        .iReady(iReady), .oBlock(oBlock), .oChipselect_n(oChipselect_n),
        .oWrite_n(oWrite_n), .oRead_n(oRead_n), .oAddress(oAddress),
        .oDat(oDat), .iDat(iDat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- PRESENT-80 reference ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] k_in);
        logic [63:0] s;
        logic [63:0] p;
        logic [79:0] k;
        s = pt;
        k = k_in;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
            p = '0;
            for (int i = 0; i < 63; i++) p[(i*16) % 63] = s[i];
            p[63] = s[63];
            s = p;
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // ---------------- wrapper model ----------------
    logic [31:0] w_key_hi = '0, w_key_mid = '0, w_key_lo = '0, w_ctrl = '0;
    logic [31:0] w_dat_hi = '0, w_dat_lo = '0, rdata = '0;
    logic        w_load = 1'b0;
    logic [63:0] w_res = '0, w_pending = '0;
    int          core_cnt = 0;

    assign iDat = rdata;

    always @(posedge clk) begin
        if (core_cnt > 0) begin
            if (core_cnt == 1) w_res <= w_pending;
            core_cnt <= core_cnt - 1;
        end
        if (!oChipselect_n) begin
            if (!oWrite_n) begin
                case (oAddress)
                    ADDR_LOAD:    w_load    <= oDat[0];
                    ADDR_KEY_LO:  w_key_lo  <= oDat;
                    ADDR_KEY_MID: w_key_mid <= oDat;
                    ADDR_KEY_HI:  w_key_hi  <= oDat;
                    ADDR_DAT_LO:  w_dat_lo  <= oDat;
                    ADDR_DAT_HI:  w_dat_hi  <= oDat;
                    ADDR_CTRL:    w_ctrl    <= oDat;
                    default: ;
                endcase
            end else if (!oRead_n) begin
                case (oAddress)
                    ADDR_RES_LO: rdata <= w_res[31:0];
                    ADDR_RES_HI: rdata <= w_res[63:32];
                    default:     rdata <= 32'hDEAD_BEEF;
                endcase
            end else begin
                if (w_load) begin
                    core_cnt  <= MODEL_LAT;
                    w_pending <= (w_ctrl == 32'h0 && w_key_lo[31:16] == 16'h0)
                                 ? present_enc({w_dat_hi, w_dat_lo}, {w_key_hi, w_key_mid, w_key_lo[15:0]})
                                 : 64'hBAD0_BAD0_BAD0_BAD0;
                end
                w_load <= 1'b0;
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic [5:0] bus_log[$];
    bit         clash = 1'b0;

    always @(negedge clk) begin
        if (!oChipselect_n) begin
            if (!oWrite_n && !oRead_n) clash = 1'b1;
            bus_log.push_back({oAddress, oWrite_n, oRead_n});
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic offer(input logic [79:0] k, input logic [63:0] b);
        iValid = 1'b1;
        iKey   = k;
        iBlock = b;
        iMode  = 1'b0;
    endtask

    task automatic wait_accept(output int acc, output bit ok);
        ok  = 1'b0;
        acc = 0;
        for (int i = 0; i < 100; i++) begin
            if (oReady === 1'b1) begin
                acc = cyc + 1;
                ok  = 1'b1;
                @(negedge clk);
                iValid = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(output int vc, output bit ok);
        ok = 1'b0;
        vc = 0;
        for (int i = 0; i < 200; i++) begin
            if (oValid === 1'b1) begin
                vc = cyc;
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic take_result();
        iReady = 1'b1;
        @(negedge clk);
        iReady = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({oValid, oBlock, oChipselect_n, oWrite_n, oRead_n, oAddress, oDat} !==
            {1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b blk=%h cs=%b wr=%b rd=%b addr=%h dat=%h, required idle/zero",
                     oValid, oBlock, oChipselect_n, oWrite_n, oRead_n, oAddress, oDat);
        end
        iReset = 1'b0;
        @(negedge clk);
        checks++;
        if (oReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: oReady=%b required 1", oReady);
        end
        checks++;
        if ({oValid, oChipselect_n} !== 2'b01) begin
            errors++;
            $display("FAIL reset_release_idle: valid=%b cs=%b required 0/1", oValid, oChipselect_n);
        end
    endtask

    task automatic test_first_block();
        int acc, vc;
        bit ok_a, ok_v;
        logic [5:0] exp_seq[10];
        exp_seq = '{{4'h3, 2'b01}, {4'h2, 2'b01}, {4'h1, 2'b01}, {4'h8, 2'b01},
                    {4'h5, 2'b01}, {4'h4, 2'b01}, {4'h0, 2'b01}, {4'h0, 2'b11},
                    {4'h7, 2'b10}, {4'h6, 2'b10}};
        bus_log.delete();
        offer(80'h0, 64'h0);
        wait_accept(acc, ok_a);
        wait_valid(vc, ok_v);
        checks++;
        if (!(ok_a && ok_v) || oBlock !== 64'h5579C1387B228445) begin
            errors++;
            $display("FAIL first_result: got %h (handshake %b%b) required 5579c1387b228445", oBlock, ok_a, ok_v);
        end
        checks++;
        if (vc - acc != LAT_KEY) begin
            errors++;
            $display("FAIL first_latency: got %0d required %0d", vc - acc, LAT_KEY);
        end
        checks++;
        if (bus_log.size() != 10) begin
            errors++;
            $display("FAIL first_access_count: got %0d required 10", bus_log.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (bus_log[i] !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL first_access_seq[%0d]: got addr=%h wr_n/rd_n=%b required addr=%h wr_n/rd_n=%b",
                             i, bus_log[i][5:2], bus_log[i][1:0], exp_seq[i][5:2], exp_seq[i][1:0]);
                    break;
                end
            end
        end
        take_result();
        checks++;
        if ({oValid, oReady} !== 2'b01) begin
            errors++;
            $display("FAIL first_release: valid=%b ready=%b required 0/1", oValid, oReady);
        end
    endtask

    task automatic test_same_key();
        int acc, vc;
        bit ok_a, ok_v;
        bus_log.delete();
        iReady = 1'b1;
        offer(80'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_accept(acc, ok_a);
        wait_valid(vc, ok_v);
        checks++;
        if (!(ok_a && ok_v) || oBlock !== 64'hA112FFC72F68417B) begin
            errors++;
            $display("FAIL same_key_result: got %h required a112ffc72f68417b", oBlock);
        end
        checks++;
        if (vc - acc != LAT_NOKEY) begin
            errors++;
            $display("FAIL same_key_latency: got %0d required %0d", vc - acc, LAT_NOKEY);
        end
        checks++;
        if (bus_log.size() != 6 || bus_log[0][5:2] !== ADDR_DAT_HI) begin
            errors++;
            $display("FAIL same_key_no_key_write: accesses=%0d required 6 starting at addr 5", bus_log.size());
        end
        @(negedge clk);
        iReady = 1'b0;
        checks++;
        if ({oValid, oReady} !== 2'b01) begin
            errors++;
            $display("FAIL early_ready_release: valid=%b ready=%b required 0/1", oValid, oReady);
        end
    endtask

    task automatic test_new_key();
        int acc, vc;
        bit ok_a, ok_v;
        bus_log.delete();
        offer(80'hFFFF_FFFFFFFF_FFFFFFFF, 64'h0);
        wait_accept(acc, ok_a);
        wait_valid(vc, ok_v);
        checks++;
        if (!(ok_a && ok_v) || oBlock !== 64'hE72C46C0F5945049) begin
            errors++;
            $display("FAIL new_key_result: got %h required e72c46c0f5945049", oBlock);
        end
        checks++;
        if (bus_log.size() != 10 || bus_log[0][5:2] !== ADDR_KEY_HI || vc - acc != LAT_KEY) begin
            errors++;
            $display("FAIL new_key_rewrite: accesses=%0d latency=%0d required 10 and %0d", bus_log.size(), vc - acc, LAT_KEY);
        end
        take_result();
        bus_log.delete();
        offer(80'hFFFF_FFFFFFFF_FFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_accept(acc, ok_a);
        wait_valid(vc, ok_v);
        checks++;
        if (!(ok_a && ok_v) || oBlock !== 64'h3333DCD3213210D2) begin
            errors++;
            $display("FAIL new_key_ones_result: got %h required 3333dcd3213210d2", oBlock);
        end
        checks++;
        if (bus_log.size() != 6) begin
            errors++;
            $display("FAIL new_key_ones_accesses: got %0d required 6", bus_log.size());
        end
        take_result();
    endtask

    task automatic test_back_to_back();
        int acc, vc, hs;
        bit ok_a, ok_v;
        offer(80'hFFFF_FFFFFFFF_FFFFFFFF, 64'h0);
        wait_accept(acc, ok_a);
        wait_valid(vc, ok_v);
        offer(80'h0, 64'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({oValid, oReady, oBlock} !== {1'b1, 1'b0, 64'hE72C46C0F5945049}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b blk=%h required 1/0/e72c46c0f5945049",
                         i, oValid, oReady, oBlock);
            end
        end
        bus_log.delete();
        iReady = 1'b1;
        hs = cyc + 1;
        @(negedge clk);
        iReady = 1'b0;
        checks++;
        if ({oValid, oReady} !== 2'b01) begin
            errors++;
            $display("FAIL backpressure_release: valid=%b ready=%b required 0/1", oValid, oReady);
        end
        wait_accept(acc, ok_a);
        checks++;
        if (!ok_a || acc != hs + 1) begin
            errors++;
            $display("FAIL second_accept_edge: got %0d required %0d", acc, hs + 1);
        end
        wait_valid(vc, ok_v);
        checks++;
        if (!ok_v || oBlock !== 64'h5579C1387B228445 || bus_log.size() == 0 || bus_log[0][5:2] !== ADDR_KEY_HI) begin
            errors++;
            $display("FAIL second_block_result: got %h accesses=%0d required 5579c1387b228445 with key rewrite",
                     oBlock, bus_log.size());
        end
        take_result();
    endtask

    task automatic test_reset_abort();
        int acc, vc;
        bit ok_a, ok_v, seen;
        offer(80'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_accept(acc, ok_a);
        repeat (15) @(negedge clk);
        iReset = 1'b1;
        #1;
        checks++;
        if ({oValid, oBlock, oChipselect_n, oWrite_n, oRead_n, oAddress, oDat, oReady} !==
            {1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL abort_reset_outputs: valid=%b blk=%h cs=%b addr=%h ready=%b required reset values",
                     oValid, oBlock, oChipselect_n, oAddress, oReady);
        end
        @(negedge clk);
        @(negedge clk);
        iReset = 1'b0;
        bus_log.delete();
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (oValid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || bus_log.size() != 0) begin
            errors++;
            $display("FAIL abort_no_result: valid_seen=%b accesses=%0d required 0/0", seen, bus_log.size());
        end
        offer(80'h0, 64'h0);
        wait_accept(acc, ok_a);
        wait_valid(vc, ok_v);
        checks++;
        if (!(ok_a && ok_v) || oBlock !== 64'h5579C1387B228445) begin
            errors++;
            $display("FAIL abort_next_result: got %h required 5579c1387b228445", oBlock);
        end
        checks++;
        if (bus_log.size() != 10 || bus_log[0][5:2] !== ADDR_KEY_HI || vc - acc != LAT_KEY) begin
            errors++;
            $display("FAIL abort_key_rewrite: accesses=%0d latency=%0d required 10 and %0d",
                     bus_log.size(), vc - acc, LAT_KEY);
        end
        take_result();
        checks++;
        if (clash !== 1'b0) begin
            errors++;
            $display("FAIL strobe_clash: got %b required 0", clash);
        end
    endtask

    initial begin
        iReset = 1'b1;
        iValid = 1'b0;
        iReady = 1'b0;
        iBlock = '0;
        iKey   = '0;
        iMode  = 1'b0;
        test_reset();
        test_first_block();
        test_same_key();
        test_new_key();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
